// File: rtl/out_port_arbiter_pkg.sv
// Shared types and helpers for the out_port write arbiter.
// State encoding, default sizes and a constant log2 helper.
package out_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search starting just above the last grant.
// Indices above the pointer beat those at or below it; lowest index wins within each half.
module rr_priority_picker
    import out_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               any_valid
);

    logic           hi_hit;
    logic           lo_hit;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    // Descending scan so the last hit written is the lowest index.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) > ptr)) begin
                hi_hit = 1'b1;
                hi_idx = IDW'(i);
            end
            if (req_valid[i] && (IDW'(i) <= ptr)) begin
                lo_hit = 1'b1;
                lo_idx = IDW'(i);
            end
        end
    end

    assign winner    = hi_hit ? hi_idx : lo_idx;
    assign any_valid = hi_hit | lo_hit;

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing the out_port write interface among requesters,
// with a programmable dead time after each write pulse.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAP_CYCLES = 8,
    parameter int GAP_WIDTH  = 16
) (
    input  logic                          w_clk_low,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          write_enable,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
    output logic                          busy
);

    localparam int IDW = clog2(NUM_REQ);
    localparam logic [GAP_WIDTH-1:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? '0 : GAP_WIDTH'(GAP_CYCLES - 1);

    state_t               state;
    state_t               state_nx;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       winner;
    logic                 any_valid;
    logic                 accept;
    logic [GAP_WIDTH-1:0] gap_cnt;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Ready is suppressed under reset so nothing is accepted that reset would drop.
    assign accept       = (state == IDLE) && any_valid && !rst;
    assign req_ready    = accept ? (NUM_REQ'(1) << winner) : '0;
    assign write_enable = (state == WRITE);
    assign busy         = (state == WRITE) || (state == GAP);

    always_ff @(posedge w_clk_low) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (GAP_CYCLES == 0) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge w_clk_low) begin
        if (rst) begin
            ptr        <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            write_data <= '0;
            gap_cnt    <= '0;
        end else begin
            if (accept) begin
                ptr        <= winner;
                grant_id   <= winner;
                write_data <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == WRITE) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: an 8-cycle-gap instance and a
// zero-gap instance sharing clock and reset.
module tb_out_port_arbiter;

    logic         clk;
    logic         rst;

    logic [3:0]   v0;
    logic [127:0] d0;
    logic [3:0]   rdy0;
    logic [31:0]  wd0;
    logic         we0;
    logic [1:0]   gid0;
    logic         busy0;

    logic [3:0]   v1;
    logic [127:0] d1;
    logic [3:0]   rdy1;
    logic [31:0]  wd1;
    logic         we1;
    logic [1:0]   gid1;
    logic         busy1;

    int n_checks = 0;
    int n_fail   = 0;

    out_port_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .GAP_CYCLES (8),
        .GAP_WIDTH  (16)
    ) dut0 (
        .w_clk_low    (clk),
        .rst          (rst),
        .req_valid    (v0),
        .req_data     (d0),
        .req_ready    (rdy0),
        .write_data   (wd0),
        .write_enable (we0),
        .grant_id     (gid0),
        .busy         (busy0)
    );

    out_port_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .GAP_CYCLES (0),
        .GAP_WIDTH  (16)
    ) dut1 (
        .w_clk_low    (clk),
        .rst          (rst),
        .req_valid    (v1),
        .req_data     (d1),
        .req_ready    (rdy1),
        .write_data   (wd1),
        .write_enable (we1),
        .grant_id     (gid1),
        .busy         (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy0 && n < 30) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(busy0), 64'd0);
    endtask

    initial begin
        int cnt;
        logic [1:0]  exp_gid [4];
        logic [31:0] exp_wd  [4];

        rst = 1'b1;
        v0  = 4'b1111;
        d0  = {32'h44, 32'h33, 32'h22, 32'h11};
        v1  = 4'b0000;
        d1  = {32'h5A3, 32'h5A2, 32'h5A1, 32'h5A0};

        // Reset held with all requesters valid
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(rdy0), 64'd0);
            chk("rst_we", 64'(we0), 64'd0);
            chk("rst_wd", 64'(wd0), 64'd0);
            chk("rst_busy", 64'(busy0), 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(rdy0), 64'b0001);
        tick();
        chk("first_we", 64'(we0), 64'd1);
        chk("first_gid", 64'(gid0), 64'd0);
        chk("first_wd", 64'(wd0), 64'h11);

        // Full contention: order 1,2,3,0 at 10-cycle spacing
        exp_gid = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_wd  = '{32'h22, 32'h33, 32'h44, 32'h11};
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!we0 && cnt < 20);
            chk("cont_spacing", 64'(cnt), 64'd10);
            chk("cont_gid", 64'(gid0), 64'(exp_gid[k]));
            chk("cont_wd", 64'(wd0), 64'(exp_wd[k]));
        end
        v0 = 4'b0000;
        wait_idle();

        // Single requester 2
        d0[2*32 +: 32] = 32'hA5;
        v0 = 4'b0100;
        #1;
        chk("single_ready", 64'(rdy0), 64'b0100);
        tick();
        chk("single_we", 64'(we0), 64'd1);
        chk("single_wd", 64'(wd0), 64'hA5);
        chk("single_gid", 64'(gid0), 64'd2);
        chk("single_busy", 64'(busy0), 64'd1);
        chk("single_ready_w", 64'(rdy0), 64'd0);
        for (int i = 2; i <= 9; i++) begin
            tick();
            chk("gap_busy", 64'(busy0), 64'd1);
            chk("gap_ready", 64'(rdy0), 64'd0);
            chk("gap_we", 64'(we0), 64'd0);
        end
        tick();
        chk("gap_end_busy", 64'(busy0), 64'd0);
        chk("gap_end_ready", 64'(rdy0), 64'b0100);
        chk("hold_wd", 64'(wd0), 64'hA5);
        v0 = 4'b0000;
        #1;
        chk("drop_ready", 64'(rdy0), 64'd0);

        // Withdrawn request: 1 drops during gap, 3 must win
        v0 = 4'b0001;
        #1;
        chk("wd_ready0", 64'(rdy0), 64'b0001);
        tick();
        chk("wd_gid0", 64'(gid0), 64'd0);
        v0 = 4'b1010;
        #1;
        chk("wd_ready_w", 64'(rdy0), 64'd0);
        tick();
        chk("wd_ready_g", 64'(rdy0), 64'd0);
        tick();
        v0 = 4'b1000;
        cnt = 0;
        while (busy0 && cnt < 20) begin
            chk("wd_ready_busy", 64'(rdy0), 64'd0);
            tick();
            cnt++;
        end
        chk("wd_idle", 64'(busy0), 64'd0);
        chk("wd_ready3", 64'(rdy0), 64'b1000);
        tick();
        chk("wd_we", 64'(we0), 64'd1);
        chk("wd_gid3", 64'(gid0), 64'd3);
        chk("wd_wd", 64'(wd0), 64'h44);

        // Move pointer to 1
        v0 = 4'b0010;
        wait_idle();
        chk("p1_ready", 64'(rdy0), 64'b0010);
        tick();
        v0 = 4'b0000;
        wait_idle();

        // Reset in the accept cycle
        v0 = 4'b0011;
        #1;
        chk("ra_ready", 64'(rdy0), 64'b0001);
        rst = 1'b1;
        #1;
        chk("ra_ready_rst", 64'(rdy0), 64'd0);
        tick();
        chk("ra_we", 64'(we0), 64'd0);
        chk("ra_busy", 64'(busy0), 64'd0);
        chk("ra_wd", 64'(wd0), 64'd0);
        rst = 1'b0;
        v0  = 4'b0110;
        #1;
        chk("ra_next_ready", 64'(rdy0), 64'b0010);
        tick();
        chk("ra_next_we", 64'(we0), 64'd1);
        chk("ra_next_gid", 64'(gid0), 64'd1);
        chk("ra_next_wd", 64'(wd0), 64'h22);
        v0 = 4'b0000;
        wait_idle();

        // Zero-gap instance: 1 and 3 alternate every 2 cycles
        v1 = 4'b1010;
        #1;
        chk("z_ready", 64'(rdy1), 64'b0010);
        exp_gid = '{2'd1, 2'd3, 2'd1, 2'd3};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("z_we", 64'(we1), 64'd1);
            chk("z_gid", 64'(gid1), 64'(exp_gid[k]));
            chk("z_wd", 64'(wd1), exp_gid[k] == 2'd1 ? 64'h5A1 : 64'h5A3);
            chk("z_busy", 64'(busy1), 64'd1);
            tick();
            chk("z_we_low", 64'(we1), 64'd0);
        end
        v1 = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
